// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
//   - width constants for address, data, strobe and size fields
//   - arbiter state encoding, owner encoding, transfer size codes
//   - bus_cmd_t: the command payload held on the registered bus side
package sram_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/sram_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-like bus port between the
// instruction fetch port (I) and the load/store port (D). D has fixed priority.
// A flush cancels an unaccepted fetch, or discards the data of an accepted one.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         pipeline flush pulse (port I only)
//   i_req, i_addr                 fetch request, held until i_addr_ok
//   d_req, d_addr, d_wr, d_size,  load/store request, held until d_addr_ok
//   d_wstrb, d_wdata
//   i_addr_ok, d_addr_ok          combinational accept pulses
//   i_data_ok/i_rdata,            registered completion pulse and read data
//   d_data_ok/d_rdata
//   bus_req, bus_wr, bus_size,    registered bus command
//   bus_wstrb, bus_addr, bus_wdata
//   bus_addr_ok, bus_data_ok,     slave handshakes and read data
//   bus_rdata
//   busy                          arbiter not idle
module sram_arbiter
    import sram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr,
    input  logic [SIZE_W-1:0] d_size,
    input  logic [STRB_W-1:0] d_wstrb,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              i_addr_ok,
    output logic              d_addr_ok,
    output logic              i_data_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [SIZE_W-1:0] bus_size,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    state_t            state, state_n;
    owner_t            own, own_n;
    bus_cmd_t          cmd, cmd_n;
    logic              req_q, req_n;
    logic              cancel, cancel_n;
    logic              i_data_ok_n, d_data_ok_n;
    logic [DATA_W-1:0] i_rdata_n, d_rdata_n;
    logic              busy_n;
    logic              accept;

    // Slave accepts only while a request is actually presented in ADDR.
    assign accept    = (state == ST_ADDR) && req_q && bus_addr_ok;
    assign i_addr_ok = accept && (own == OWN_I);
    assign d_addr_ok = accept && (own == OWN_D);

    assign bus_req   = req_q;
    assign bus_wr    = cmd.wr;
    assign bus_size  = cmd.size;
    assign bus_wstrb = cmd.wstrb;
    assign bus_addr  = cmd.addr;
    assign bus_wdata = cmd.wdata;

    // Next-state, bus command and completion logic.
    always_comb begin
        state_n     = state;
        own_n       = own;
        cmd_n       = cmd;
        req_n       = req_q;
        cancel_n    = cancel;
        i_data_ok_n = 1'b0;
        d_data_ok_n = 1'b0;
        i_rdata_n   = i_rdata;
        d_rdata_n   = d_rdata;

        case (state)
            ST_IDLE: begin
                if (d_req) begin
                    cmd_n    = '{wr: d_wr, size: d_size, wstrb: d_wstrb,
                                 addr: d_addr, wdata: d_wdata};
                    own_n    = OWN_D;
                    req_n    = 1'b1;
                    cancel_n = 1'b0;
                    state_n  = ST_ADDR;
                end else if (i_req && !flush) begin
                    cmd_n    = '{wr: 1'b0, size: SIZE_WORD, wstrb: STRB_W'(0),
                                 addr: i_addr, wdata: DATA_W'(0)};
                    own_n    = OWN_I;
                    req_n    = 1'b1;
                    cancel_n = 1'b0;
                    state_n  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (accept) begin
                    req_n   = 1'b0;
                    state_n = ST_DATA;
                    // Accepted in the flush cycle: data must still be drained.
                    if ((own == OWN_I) && flush) begin
                        cancel_n = 1'b1;
                    end
                end else if ((own == OWN_I) && flush) begin
                    req_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    state_n  = ST_IDLE;
                    cancel_n = 1'b0;
                    if (own == OWN_D) begin
                        d_rdata_n   = bus_rdata;
                        d_data_ok_n = 1'b1;
                    end else begin
                        i_rdata_n   = bus_rdata;
                        // A flush landing on the return cycle also discards it.
                        i_data_ok_n = !cancel && !flush;
                    end
                end else if ((own == OWN_I) && flush) begin
                    cancel_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                req_n   = 1'b0;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            own       <= OWN_I;
            cmd       <= '0;
            req_q     <= 1'b0;
            cancel    <= 1'b0;
            i_data_ok <= 1'b0;
            d_data_ok <= 1'b0;
            i_rdata   <= DATA_W'(0);
            d_rdata   <= DATA_W'(0);
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            own       <= own_n;
            cmd       <= cmd_n;
            req_q     <= req_n;
            cancel    <= cancel_n;
            i_data_ok <= i_data_ok_n;
            d_data_ok <= d_data_ok_n;
            i_rdata   <= i_rdata_n;
            d_rdata   <= d_rdata_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
    logic        i_addr_ok;
    logic        d_addr_ok;
    logic        i_data_ok;
    logic        d_data_ok;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;

    int checks;
    int passed;

    sram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .d_req       (d_req),
        .d_addr      (d_addr),
        .d_wr        (d_wr),
        .d_size      (d_size),
        .d_wstrb     (d_wstrb),
        .d_wdata     (d_wdata),
        .i_addr_ok   (i_addr_ok),
        .d_addr_ok   (d_addr_ok),
        .i_data_ok   (i_data_ok),
        .d_data_ok   (d_data_ok),
        .i_rdata     (i_rdata),
        .d_rdata     (d_rdata),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_wr = 0;
        d_size = 0; d_wstrb = 0; d_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        cyc(); cyc();
        mid();
        checks++; if (bus_req !== 1'b0) $display("FAIL reset_bus_req got=%0h exp=0", bus_req); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", busy); else passed++;
        checks++; if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 4'b0) $display("FAIL reset_oks got=%b exp=0000", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}); else passed++;
        checks++; if ({bus_addr, bus_wdata, i_rdata, d_rdata} !== 128'b0) $display("FAIL reset_data got=%h exp=0", {bus_addr, bus_wdata, i_rdata, d_rdata}); else passed++;
        checks++; if ({bus_wr, bus_size, bus_wstrb} !== 7'b0) $display("FAIL reset_fields got=%b exp=0", {bus_wr, bus_size, bus_wstrb}); else passed++;
        cyc();
        rst = 0;
        cyc();
    endtask

    task automatic test_d_load();
        d_req = 1; d_addr = 32'h0000_1000; d_wr = 0; d_size = 2'd2; d_wstrb = 4'h0;
        mid();
        checks++; if (d_addr_ok !== 1'b0) $display("FAIL load_t0_addr_ok got=%0h exp=0", d_addr_ok); else passed++;
        cyc();
        bus_addr_ok = 1;
        mid();
        checks++; if (bus_req !== 1'b1) $display("FAIL load_bus_req got=%0h exp=1", bus_req); else passed++;
        checks++; if ({bus_addr, bus_wr, bus_size} !== {32'h0000_1000, 1'b0, 2'd2}) $display("FAIL load_bus_fields got=%h exp=%h", {bus_addr, bus_wr, bus_size}, {32'h0000_1000, 1'b0, 2'd2}); else passed++;
        checks++; if ({d_addr_ok, i_addr_ok} !== 2'b10) $display("FAIL load_addr_ok got=%b exp=10", {d_addr_ok, i_addr_ok}); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL load_busy got=%0h exp=1", busy); else passed++;
        cyc();
        d_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;
        mid();
        checks++; if ({bus_req, d_addr_ok, d_data_ok} !== 3'b000) $display("FAIL load_t2 got=%b exp=000", {bus_req, d_addr_ok, d_data_ok}); else passed++;
        cyc();
        bus_data_ok = 0; bus_rdata = 0;
        mid();
        checks++; if (d_data_ok !== 1'b1) $display("FAIL load_data_ok got=%0h exp=1", d_data_ok); else passed++;
        checks++; if (d_rdata !== 32'hDEAD_BEEF) $display("FAIL load_rdata got=%h exp=deadbeef", d_rdata); else passed++;
        checks++; if ({i_data_ok, busy} !== 2'b00) $display("FAIL load_t3_idle got=%b exp=00", {i_data_ok, busy}); else passed++;
        cyc();
        mid();
        checks++; if (d_data_ok !== 1'b0) $display("FAIL load_data_ok_pulse got=%0h exp=0", d_data_ok); else passed++;
        cyc();
    endtask

    task automatic test_both();
        i_req = 1; i_addr = 32'h0000_2000;
        d_req = 1; d_addr = 32'h0000_3004; d_wr = 1; d_size = 2'd1; d_wstrb = 4'h3; d_wdata = 32'h0000_A5A5;
        cyc();
        bus_addr_ok = 1;
        mid();
        checks++; if ({bus_wr, bus_size, bus_wstrb} !== {1'b1, 2'd1, 4'h3}) $display("FAIL both_store_ctl got=%b exp=%b", {bus_wr, bus_size, bus_wstrb}, {1'b1, 2'd1, 4'h3}); else passed++;
        checks++; if ({bus_addr, bus_wdata} !== {32'h0000_3004, 32'h0000_A5A5}) $display("FAIL both_store_data got=%h exp=%h", {bus_addr, bus_wdata}, {32'h0000_3004, 32'h0000_A5A5}); else passed++;
        checks++; if ({d_addr_ok, i_addr_ok} !== 2'b10) $display("FAIL both_d_addr_ok got=%b exp=10", {d_addr_ok, i_addr_ok}); else passed++;
        cyc();
        d_req = 0; d_wr = 0; bus_addr_ok = 0; bus_data_ok = 1;
        mid();
        checks++; if (i_addr_ok !== 1'b0) $display("FAIL both_i_wait got=%0h exp=0", i_addr_ok); else passed++;
        cyc();
        bus_data_ok = 0;
        mid();
        checks++; if ({d_data_ok, i_data_ok} !== 2'b10) $display("FAIL both_d_done got=%b exp=10", {d_data_ok, i_data_ok}); else passed++;
        cyc();
        bus_addr_ok = 1;
        mid();
        checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h0000_2000}) $display("FAIL both_fetch_bus got=%h exp=%h", {bus_req, bus_addr}, {1'b1, 32'h0000_2000}); else passed++;
        checks++; if ({bus_wr, bus_size, bus_wstrb} !== {1'b0, 2'd2, 4'h0}) $display("FAIL both_fetch_ctl got=%b exp=%b", {bus_wr, bus_size, bus_wstrb}, {1'b0, 2'd2, 4'h0}); else passed++;
        checks++; if ({i_addr_ok, d_addr_ok} !== 2'b10) $display("FAIL both_i_addr_ok got=%b exp=10", {i_addr_ok, d_addr_ok}); else passed++;
        cyc();
        i_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1357_9BDF;
        cyc();
        bus_data_ok = 0; bus_rdata = 0;
        mid();
        checks++; if ({i_data_ok, d_data_ok} !== 2'b10) $display("FAIL both_i_done got=%b exp=10", {i_data_ok, d_data_ok}); else passed++;
        checks++; if (i_rdata !== 32'h1357_9BDF) $display("FAIL both_i_rdata got=%h exp=13579bdf", i_rdata); else passed++;
        cyc();
    endtask

    task automatic test_addr_stall();
        d_req = 1; d_addr = 32'h0000_4000; d_wr = 0; d_size = 2'd0; d_wstrb = 4'h0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            bus_addr_ok = 0;
            flush = (k == 1);
            mid();
            checks++; if ({bus_req, bus_addr, bus_size} !== {1'b1, 32'h0000_4000, 2'd0}) $display("FAIL stall_fields_%0d got=%h exp=%h", k, {bus_req, bus_addr, bus_size}, {1'b1, 32'h0000_4000, 2'd0}); else passed++;
            checks++; if (d_addr_ok !== 1'b0) $display("FAIL stall_addr_ok_%0d got=%0h exp=0", k, d_addr_ok); else passed++;
            cyc();
        end
        flush = 0; bus_addr_ok = 1;
        mid();
        checks++; if ({d_addr_ok, bus_addr} !== {1'b1, 32'h0000_4000}) $display("FAIL stall_accept got=%h exp=%h", {d_addr_ok, bus_addr}, {1'b1, 32'h0000_4000}); else passed++;
        cyc();
        d_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0BAD_F00D;
        cyc();
        bus_data_ok = 0; bus_rdata = 0;
        mid();
        checks++; if ({d_data_ok, d_rdata} !== {1'b1, 32'h0BAD_F00D}) $display("FAIL stall_done got=%h exp=%h", {d_data_ok, d_rdata}, {1'b1, 32'h0BAD_F00D}); else passed++;
        cyc();
    endtask

    task automatic test_flush_addr();
        i_req = 1; i_addr = 32'h0000_5000;
        cyc();
        flush = 1; bus_addr_ok = 0;
        mid();
        checks++; if ({bus_req, i_addr_ok} !== 2'b10) $display("FAIL fla_t1 got=%b exp=10", {bus_req, i_addr_ok}); else passed++;
        cyc();
        flush = 0; i_req = 0; bus_data_ok = 1; bus_rdata = 32'hFFFF_0000;
        mid();
        checks++; if ({bus_req, busy, i_addr_ok} !== 3'b000) $display("FAIL fla_abandon got=%b exp=000", {bus_req, busy, i_addr_ok}); else passed++;
        cyc();
        bus_data_ok = 0; bus_rdata = 0;
        mid();
        checks++; if ({i_data_ok, bus_req, busy} !== 3'b000) $display("FAIL fla_no_data got=%b exp=000", {i_data_ok, bus_req, busy}); else passed++;
        cyc();
    endtask

    task automatic test_flush_accept();
        i_req = 1; i_addr = 32'h0000_7000;
        cyc();
        flush = 1; bus_addr_ok = 1;
        mid();
        checks++; if (i_addr_ok !== 1'b1) $display("FAIL flacc_addr_ok got=%0h exp=1", i_addr_ok); else passed++;
        cyc();
        flush = 0; i_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h7777_7777;
        mid();
        checks++; if (busy !== 1'b1) $display("FAIL flacc_busy got=%0h exp=1", busy); else passed++;
        cyc();
        bus_data_ok = 0; bus_rdata = 0;
        mid();
        checks++; if ({i_data_ok, busy} !== 2'b00) $display("FAIL flacc_suppress got=%b exp=00", {i_data_ok, busy}); else passed++;
        cyc();
    endtask

    task automatic test_flush_data();
        i_req = 1; i_addr = 32'h0000_6000;
        cyc();
        bus_addr_ok = 1;
        mid();
        checks++; if (i_addr_ok !== 1'b1) $display("FAIL fld_addr_ok got=%0h exp=1", i_addr_ok); else passed++;
        cyc();
        i_req = 0; bus_addr_ok = 0; flush = 1;
        mid();
        checks++; if (busy !== 1'b1) $display("FAIL fld_busy got=%0h exp=1", busy); else passed++;
        cyc();
        flush = 0; bus_data_ok = 1; bus_rdata = 32'h1111_2222;
        cyc();
        bus_data_ok = 0; bus_rdata = 0;
        i_req = 1; i_addr = 32'h0000_6010;
        mid();
        checks++; if ({i_data_ok, busy} !== 2'b00) $display("FAIL fld_suppress got=%b exp=00", {i_data_ok, busy}); else passed++;
        cyc();
        bus_addr_ok = 1;
        mid();
        checks++; if ({i_addr_ok, bus_addr} !== {1'b1, 32'h0000_6010}) $display("FAIL fld_next_req got=%h exp=%h", {i_addr_ok, bus_addr}, {1'b1, 32'h0000_6010}); else passed++;
        cyc();
        i_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3333_4444;
        cyc();
        bus_data_ok = 0; bus_rdata = 0;
        mid();
        checks++; if ({i_data_ok, i_rdata} !== {1'b1, 32'h3333_4444}) $display("FAIL fld_next_done got=%h exp=%h", {i_data_ok, i_rdata}, {1'b1, 32'h3333_4444}); else passed++;
        cyc();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_addr = 32'h0000_8000; d_wr = 0; d_size = 2'd2;
        cyc();
        bus_addr_ok = 1;
        cyc();
        d_req = 0; bus_addr_ok = 0; rst = 1;
        cyc();
        rst = 0; bus_data_ok = 1; bus_rdata = 32'hCAFE_F00D;
        mid();
        checks++; if ({bus_req, busy, d_data_ok, d_addr_ok} !== 4'b0000) $display("FAIL rstmid_ctl got=%b exp=0000", {bus_req, busy, d_data_ok, d_addr_ok}); else passed++;
        checks++; if ({bus_addr, d_rdata} !== 64'b0) $display("FAIL rstmid_data got=%h exp=0", {bus_addr, d_rdata}); else passed++;
        cyc();
        bus_data_ok = 0; bus_rdata = 0;
        mid();
        checks++; if ({d_data_ok, i_data_ok, busy} !== 3'b000) $display("FAIL rstmid_late_data got=%b exp=000", {d_data_ok, i_data_ok, busy}); else passed++;
        cyc();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_d_load();
        test_both();
        test_addr_stall();
        test_flush_addr();
        test_flush_accept();
        test_flush_data();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
